// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: serves in-order, fixed-latency word reads from an on-chip RAM,
// with credit-limited outstanding reads, a fall-through response queue, flush and a loader port.
module instr_mem_responder #(
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_addr,
  output logic        resp_fault,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(LATENCY + 2);
  localparam int QD   = LATENCY + 1;
  localparam int PW   = $clog2(QD);
  localparam int NW   = $clog2(QD + 1);
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        fault;
  } resp_t;

  logic [31:0]   mem [DEPTH];
  logic [CW-1:0] outstanding;
  logic          accept;
  logic          respFire;
  resp_t         lookup;
  logic          pushValid;
  resp_t         pushData;
  resp_t         queue [QD];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [NW-1:0] count;

  assign req_ready = !ld_we && !flush && (outstanding < CW'(LATENCY + 1));
  assign accept    = req_valid && req_ready;
  assign respFire  = resp_valid && resp_ready;

  // Word address limit checked on the full byte address; DEPTH*4 is word aligned.
  always_comb begin
    lookup       = '0;
    lookup.addr  = req_addr;
    lookup.fault = (req_addr[1:0] != 2'b00) || (req_addr >= BYTE_LIMIT);
    lookup.instr = lookup.fault ? NOP : mem[req_addr[AW+1:2]];
  end

  // Program RAM: never reset, so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (ld_we && (ld_addr < BYTE_LIMIT)) begin
      mem[ld_addr[AW+1:2]] <= ld_data;
    end
  end

  // The read happens at the accept edge; LATENCY-1 register stages lead into the queue.
  generate
    if (LATENCY == 1) begin : gDirect
      assign pushValid = accept;
      assign pushData  = lookup;
    end else begin : gPipe
      logic [LATENCY-2:0] pipeValid;
      resp_t              pipe [LATENCY-1];

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          pipeValid <= '0;
        end else begin
          pipeValid[0] <= accept;
          for (int k = 1; k < LATENCY - 1; k++) begin
            pipeValid[k] <= pipeValid[k-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        pipe[0] <= lookup;
        for (int k = 1; k < LATENCY - 1; k++) begin
          pipe[k] <= pipe[k-1];
        end
      end

      assign pushValid = pipeValid[LATENCY-2];
      assign pushData  = pipe[LATENCY-2];
    end
  endgenerate

  // Credit rule keeps the queue from ever overflowing, so push is never refused.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pushValid) begin
        queue[tail] <= pushData;
        tail        <= (tail == PW'(QD - 1)) ? '0 : tail + 1'b1;
      end
      if (respFire) begin
        head <= (head == PW'(QD - 1)) ? '0 : head + 1'b1;
      end
      case ({pushValid, respFire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      outstanding <= '0;
    end else begin
      case ({accept, respFire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign resp_valid = (count != '0) && !flush;
  assign resp_instr = resp_valid ? queue[head].instr : 32'h0;
  assign resp_addr  = resp_valid ? queue[head].addr  : 32'h0;
  assign resp_fault = resp_valid ? queue[head].fault : 1'b0;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed self-checking bench for instr_mem_responder (DEPTH=1024, LATENCY=2).
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        req_ready;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_instr;
  logic [31:0] resp_addr;
  logic        resp_fault;
  logic        ld_we = 1'b0;
  logic [31:0] ld_addr = 32'h0;
  logic [31:0] ld_data = 32'h0;

  int testsRun = 0;
  int testsFailed = 0;
  logic [31:0] prog [4];

  instr_mem_responder #(.DEPTH(1024), .LATENCY(2), .NOP(32'h0000_0013)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_instr(resp_instr), .resp_addr(resp_addr), .resp_fault(resp_fault),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    req_valid = 1'b0; req_addr = 32'h0; flush = 1'b0;
    ld_we = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idleInputs(); resp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    testsRun++;
    if (resp_valid !== 1'b0 || resp_instr !== 32'h0 || resp_addr !== 32'h0 || resp_fault !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: valid=%b instr=%h addr=%h fault=%b, need all 0", resp_valid, resp_instr, resp_addr, resp_fault);
    end
    testsRun++;
    if (req_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_ready: req_ready=%b, need 1", req_ready);
    end
    tick();
  endtask

  task automatic test_load();
    for (int i = 0; i < 4; i++) begin
      ld_we = 1'b1; ld_addr = 32'(i * 4); ld_data = prog[i];
      tick();
    end
    ld_we = 1'b1; ld_addr = 32'h0000_0FFC; ld_data = 32'hCAFE_F00D;
    tick();
    idleInputs();
    tick();
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 4);
      req_addr  = (c < 4) ? 32'(c * 4) : 32'h0;
      #1;
      if (c < 4) begin
        testsRun++;
        if (req_ready !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL b2b_ready c%0d: req_ready=%b, need 1", c, req_ready);
        end
      end
      if (c >= 2 && c < 6) begin
        testsRun++;
        if (resp_valid !== 1'b1 || resp_addr !== 32'((c - 2) * 4) || resp_instr !== prog[c-2] || resp_fault !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL b2b_resp c%0d: valid=%b addr=%h instr=%h fault=%b, need 1 %h %h 0",
                   c, resp_valid, resp_addr, resp_instr, resp_fault, 32'((c - 2) * 4), prog[c-2]);
        end
      end else begin
        testsRun++;
        if (resp_valid !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL b2b_idle c%0d: resp_valid=%b, need 0", c, resp_valid);
        end
      end
      tick();
    end
    idleInputs();
  endtask

  task automatic test_stall();
    int accepts;
    accepts = 0;
    resp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1;
      req_addr  = 32'(accepts * 4);
      #1;
      if (req_ready) accepts++;
      if (c >= 2) begin
        testsRun++;
        if (resp_valid !== 1'b1 || resp_instr !== prog[0] || resp_addr !== 32'h0) begin
          testsFailed++;
          $display("[TB] FAIL stall_hold c%0d: valid=%b instr=%h addr=%h, need 1 %h 0", c, resp_valid, resp_instr, resp_addr, prog[0]);
        end
      end
      tick();
    end
    testsRun++;
    if (accepts != 3 || req_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL stall_credit: accepts=%0d req_ready=%b, need 3 and 0", accepts, req_ready);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      testsRun++;
      if (c < 3) begin
        if (resp_valid !== 1'b1 || resp_addr !== 32'(c * 4) || resp_instr !== prog[c]) begin
          testsFailed++;
          $display("[TB] FAIL stall_drain c%0d: valid=%b addr=%h instr=%h, need 1 %h %h", c, resp_valid, resp_addr, resp_instr, 32'(c * 4), prog[c]);
        end
      end else if (resp_valid !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL stall_empty: resp_valid=%b, need 0", resp_valid);
      end
      tick();
    end
    idleInputs();
  endtask

  task automatic test_flush();
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1; req_addr = 32'(c * 4);
      tick();
    end
    flush = 1'b1; resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'hC;
    #1;
    testsRun++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL flush_cycle: req_ready=%b resp_valid=%b, need 0 0", req_ready, resp_valid);
    end
    tick();
    flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_valid = (c == 0);
      req_addr  = 32'h8;
      #1;
      if (c == 2) begin
        testsRun++;
        if (resp_valid !== 1'b1 || resp_instr !== 32'h0020_81B3 || resp_addr !== 32'h8) begin
          testsFailed++;
          $display("[TB] FAIL flush_reread: valid=%b instr=%h addr=%h, need 1 002081b3 8", resp_valid, resp_instr, resp_addr);
        end
      end else begin
        testsRun++;
        if (resp_valid !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL flush_stale c%0d: resp_valid=%b addr=%h, need 0", c, resp_valid, resp_addr);
        end
      end
      tick();
    end
    idleInputs();
  endtask

  task automatic test_fault();
    logic [31:0] addrs [3];
    addrs[0] = 32'h6; addrs[1] = 32'h1000; addrs[2] = 32'hFFC;
    resp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req_valid = (c < 3);
      req_addr  = (c < 3) ? addrs[c] : 32'h0;
      #1;
      if (c >= 2) begin
        testsRun++;
        if (c < 4) begin
          if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_instr !== 32'h0000_0013 || resp_addr !== addrs[c-2]) begin
            testsFailed++;
            $display("[TB] FAIL fault c%0d: valid=%b fault=%b instr=%h addr=%h, need 1 1 00000013 %h", c, resp_valid, resp_fault, resp_instr, resp_addr, addrs[c-2]);
          end
        end else if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_instr !== 32'hCAFE_F00D || resp_addr !== 32'hFFC) begin
          testsFailed++;
          $display("[TB] FAIL last_word: valid=%b fault=%b instr=%h addr=%h, need 1 0 cafef00d ffc", resp_valid, resp_fault, resp_instr, resp_addr);
        end
      end
      tick();
    end
    idleInputs();
    tick();
  endtask

  task automatic test_loader();
    resp_ready = 1'b1;
    ld_we = 1'b1; ld_addr = 32'h4; ld_data = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_addr = 32'h4;
    #1;
    testsRun++;
    if (req_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL loader_priority: req_ready=%b, need 0", req_ready);
    end
    tick();
    ld_we = 1'b0;
    tick();
    req_valid = 1'b0;
    #1;
    testsRun++;
    if (resp_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL loader_noaccept: resp_valid=%b, need 0", resp_valid);
    end
    tick();
    testsRun++;
    if (resp_valid !== 1'b1 || resp_instr !== 32'hDEAD_BEEF || resp_addr !== 32'h4) begin
      testsFailed++;
      $display("[TB] FAIL loader_newdata: valid=%b instr=%h addr=%h, need 1 deadbeef 4", resp_valid, resp_instr, resp_addr);
    end
    tick();
    idleInputs();
    tick();
  endtask

  task automatic test_reset_midop();
    int accepts;
    resp_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      req_valid = 1'b1; req_addr = 32'(c * 4);
      tick();
    end
    req_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    testsRun++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midreset_state: resp_valid=%b req_ready=%b, need 0 1", resp_valid, req_ready);
    end
    accepts = 0;
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_addr = 32'h0;
      #1;
      if (req_ready) accepts++;
      tick();
    end
    testsRun++;
    if (accepts != 3) begin
      testsFailed++;
      $display("[TB] FAIL midreset_credit: accepts=%0d, need 3", accepts);
    end
    req_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; resp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    testsRun++;
    if (resp_valid !== 1'b1 || resp_instr !== 32'h0050_0093 || resp_addr !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL ram_retained: valid=%b instr=%h addr=%h, need 1 00500093 0", resp_valid, resp_instr, resp_addr);
    end
    tick();
  endtask

  initial begin
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0000_006F;
    test_reset();
    test_load();
    test_back_to_back();
    test_stall();
    test_flush();
    test_fault();
    test_loader();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
